// File: rtl/music_sequencer_if.sv
// Song-player bus: transport controls, song ROM port and tone-generator outputs.
// The sequencer takes the slave side; whatever drives transport and hosts
// the ROM takes the master side.
interface music_sequencer_if #(
   parameter int ADDR_W = 5
);
   logic              start;
   logic              stop;
   logic              loop_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [13:0]       rom_data;
   logic [7:0]        fullnote;
   logic              playing;
   logic              done;

   modport master (
      output start, stop, loop_en, rom_data,
      input  rom_addr, fullnote, playing, done
   );

   modport slave (
      input  start, stop, loop_en, rom_data,
      output rom_addr, fullnote, playing, done
   );
endinterface

// File: rtl/music_sequencer.sv
// Melody sequencer: walks a song ROM one note entry at a time and holds each
// note code on fullnote for dur * TICK_DIV cycles. It supports start/stop,
// looping, an end-of-song pulse and an optional articulation gap per note.
module music_sequencer #(
   parameter int TICK_DIV = 1250000,
   parameter int ADDR_W   = 5,
   parameter bit ARTIC    = 1'b1
) (
   input logic              clk,
   input logic              reset,
   music_sequencer_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0]     PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2,
      PLAY  = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        note;
   logic              busy;
   logic              done_q;
   logic [5:0]        units;
   logic [PW-1:0]     presc;
   // Set when the note in the last ROM slot has finished. The address cannot
   // advance past the last slot, so the next LOAD treats this as an end marker.
   logic              wrap;

   logic [5:0]        dur;
   logic              end_seen;

   assign dur      = bus.rom_data[13:8];
   assign end_seen = wrap || (dur == 6'd0);

   assign bus.rom_addr = addr;
   assign bus.fullnote = note;
   assign bus.playing  = busy;
   assign bus.done     = done_q;

   // Sequencer FSM: state, address, counters and all outputs are registered here.
   // NOTE: every register in this block uses non-blocking assignments so that all
   // of them update from the same pre-edge values; a blocking write here would
   // let later statements see the new value and skew the cycle timing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: counters are reset too, even though LOAD reloads them before use,
         // so the block powers up in a fully known state.
         state  <= IDLE;
         addr   <= '0;
         note   <= 8'h00;
         busy   <= 1'b0;
         done_q <= 1'b0;
         units  <= 6'd0;
         presc  <= '0;
         wrap   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            // stop beats start: go silent and keep the address where it was
            state <= IDLE;
            note  <= 8'h00;
            busy  <= 1'b0;
            wrap  <= 1'b0;
         end else if (bus.start) begin
            // (re)start from the top of the song, silent until the first note loads
            state <= FETCH;
            addr  <= '0;
            note  <= 8'h00;
            busy  <= 1'b1;
            wrap  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= IDLE;
               end

               FETCH: begin
                  // ROM word for addr becomes valid one cycle after addr settles
                  state <= LOAD;
               end

               LOAD: begin
                  if (end_seen) begin
                     note <= 8'h00;
                     wrap <= 1'b0;
                     if (bus.loop_en) begin
                        addr  <= '0;
                        state <= FETCH;
                     end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done_q <= 1'b1;
                     end
                  end else begin
                     units <= dur;
                     presc <= '0;
                     note  <= bus.rom_data[7:0];
                     state <= PLAY;
                  end
               end

               PLAY: begin
                  if (presc == PRE_MAX) begin
                     presc <= '0;
                     units <= units - 6'd1;
                     if (units == 6'd1) begin
                        // last unit done: move on, or flag the end of the ROM
                        state <= FETCH;
                        if (addr == ADDR_MAX) begin
                           wrap <= 1'b1;
                        end else begin
                           addr <= addr + ADDR_W'(1);
                        end
                     end else if (ARTIC && (units == 6'd2)) begin
                        // entering the final unit of a multi-unit note: articulation gap
                        note <= 8'h00;
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: two instances (ARTIC=0 and ARTIC=1) run the same
// songs in lockstep. Expected outputs come from a per-cycle trace built
// straight from the song contents: two fetch cycles per entry, dur*TICK_DIV
// note cycles, and the end/loop/stop rules.
module tb_music_sequencer;

   localparam int T       = 4;
   localparam int AW      = 3;
   localparam int HORIZON = 600;

   typedef struct packed {
      logic [7:0]    fn;
      logic          play;
      logic          done;
      logic [AW-1:0] addr;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int n_tests = 0;
   int n_fail  = 0;
   int pos     = 0;
   logic [13:0] rom [8];
   exp_t tr_a[$];
   exp_t tr_b[$];

   music_sequencer_if #(.ADDR_W(AW)) bus_a ();
   music_sequencer_if #(.ADDR_W(AW)) bus_b ();

   music_sequencer #(.TICK_DIV(T), .ADDR_W(AW), .ARTIC(1'b0)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a)
   );
   music_sequencer #(.TICK_DIV(T), .ADDR_W(AW), .ARTIC(1'b1)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   always #5 clk = ~clk;

   // synchronous song ROMs, one read port per instance
   always @(posedge clk) begin
      bus_a.rom_data <= rom[bus_a.rom_addr];
      bus_b.rom_data <= rom[bus_b.rom_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected outputs for every cycle after a start edge.
   function automatic void build(input bit loop, input bit artic);
      exp_t q[$];
      int i;
      int d;
      logic [7:0] fn;
      logic [AW-1:0] a;
      q  = {};
      i  = 0;
      fn = 8'h00;
      while (q.size() < HORIZON) begin
         a = (i > 7) ? AW'(7) : AW'(i);
         d = (i > 7) ? 0 : int'(rom[i][13:8]);
         q.push_back(exp_t'{fn, 1'b1, 1'b0, a});
         q.push_back(exp_t'{fn, 1'b1, 1'b0, a});
         if (d == 0) begin
            fn = 8'h00;
            if (loop) begin
               i = 0;
            end else begin
               q.push_back(exp_t'{8'h00, 1'b0, 1'b1, a});
               while (q.size() < HORIZON) q.push_back(exp_t'{8'h00, 1'b0, 1'b0, a});
            end
         end else begin
            for (int k = 0; k < d * T; k++) begin
               fn = (artic && d >= 2 && k >= (d - 1) * T) ? 8'h00 : rom[i][7:0];
               q.push_back(exp_t'{fn, 1'b1, 1'b0, a});
            end
            i++;
         end
      end
      if (artic) tr_b = q;
      else       tr_a = q;
   endfunction

   function automatic void make_idle(input logic [AW-1:0] a_a, input logic [AW-1:0] a_b);
      tr_a = {};
      tr_b = {};
      for (int k = 0; k < HORIZON; k++) begin
         tr_a.push_back(exp_t'{8'h00, 1'b0, 1'b0, a_a});
         tr_b.push_back(exp_t'{8'h00, 1'b0, 1'b0, a_b});
      end
   endfunction

   task automatic cmp(input string who, input logic [7:0] fn, input logic play,
                      input logic dn, input logic [AW-1:0] addr, input exp_t e);
      check($sformatf("%s fullnote @%0d", who, pos), 32'(fn),   32'(e.fn));
      check($sformatf("%s playing @%0d",  who, pos), 32'(play), 32'(e.play));
      check($sformatf("%s done @%0d",     who, pos), 32'(dn),   32'(e.done));
      check($sformatf("%s rom_addr @%0d", who, pos), 32'(addr), 32'(e.addr));
   endtask

   // one clock: let the edge sample the inputs, drop pulses, compare outputs
   task automatic tick();
      @(posedge clk);
      #1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      bus_a.stop  = 1'b0;
      bus_b.stop  = 1'b0;
      if (pos >= HORIZON) begin
         check("trace horizon", 32'(pos), 32'(HORIZON - 1));
         pos = HORIZON - 1;
      end
      cmp("a", bus_a.fullnote, bus_a.playing, bus_a.done, bus_a.rom_addr, tr_a[pos]);
      cmp("b", bus_b.fullnote, bus_b.playing, bus_b.done, bus_b.rom_addr, tr_b[pos]);
      pos++;
   endtask

   task automatic go(input int n);
      repeat (n) tick();
   endtask

   task automatic do_start(input bit loop);
      bus_a.loop_en = loop;
      bus_b.loop_en = loop;
      bus_a.start   = 1'b1;
      bus_b.start   = 1'b1;
      build(loop, 1'b0);
      build(loop, 1'b1);
      pos = 0;
   endtask

   task automatic do_stop(input bit with_start);
      logic [AW-1:0] ha;
      logic [AW-1:0] hb;
      ha = (pos == 0) ? tr_a[0].addr : tr_a[pos - 1].addr;
      hb = (pos == 0) ? tr_b[0].addr : tr_b[pos - 1].addr;
      bus_a.stop  = 1'b1;
      bus_b.stop  = 1'b1;
      bus_a.start = with_start;
      bus_b.start = with_start;
      make_idle(ha, hb);
      pos = 0;
   endtask

   task automatic load_song1();
      for (int i = 0; i < 8; i++) rom[i] = 14'h0;
      rom[0] = {6'd2, 8'h15};
      rom[1] = {6'd1, 8'h20};
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, " a fullnote"}, 32'(bus_a.fullnote), 32'h0);
      check({tag, " a playing"},  32'(bus_a.playing),  32'h0);
      check({tag, " a rom_addr"}, 32'(bus_a.rom_addr), 32'h0);
      check({tag, " a done"},     32'(bus_a.done),     32'h0);
      check({tag, " b fullnote"}, 32'(bus_b.fullnote), 32'h0);
      check({tag, " b playing"},  32'(bus_b.playing),  32'h0);
      check({tag, " b rom_addr"}, 32'(bus_b.rom_addr), 32'h0);
   endtask

   initial begin
      bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
      bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;
      for (int i = 0; i < 8; i++) rom[i] = 14'h0;

      // reset state, observed before any clock edge
      #2 reset = 1'b1;
      #2 check_zero_outputs("reset");
      #8 reset = 1'b0;
      make_idle('0, '0);
      pos = 0;
      go(3);

      // two-note song, no loop: done after the end marker
      load_song1();
      do_start(1'b0);
      go(28);

      // same song looping: no done, song repeats from address 0
      do_start(1'b1);
      go(45);
      do_stop(1'b0);
      go(4);

      // articulation: long note goes silent for its final unit
      for (int i = 0; i < 8; i++) rom[i] = 14'h0;
      rom[0] = {6'd3, 8'h15};
      do_start(1'b0);
      go(22);

      // stop and start together mid-note: stop wins; later start restarts at 0
      load_song1();
      do_start(1'b0);
      go(6);
      do_stop(1'b1);
      go(5);
      do_start(1'b0);
      go(12);
      do_stop(1'b0);
      go(2);

      // all eight slots hold notes: end of ROM acts as end marker, no wrap to 0
      for (int i = 0; i < 8; i++) rom[i] = {6'(1 + i % 3), 8'(8'h40 + i)};
      do_start(1'b0);
      go(90);

      // same full ROM looping through the wrap
      do_start(1'b1);
      go(110);
      do_stop(1'b0);
      go(2);

      // asynchronous reset mid-note
      load_song1();
      do_start(1'b0);
      go(5);
      #2 reset = 1'b1;
      #1 check_zero_outputs("async reset");
      #3 reset = 1'b0;
      make_idle('0, '0);
      pos = 0;
      go(3);

      // randomized songs with random stop / retrigger
      for (int r = 0; r < 8; r++) begin
         bit loop;
         int act;
         for (int i = 0; i < 8; i++) begin
            rom[i][7:0]  = 8'($urandom);
            rom[i][13:8] = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 3));
         end
         loop = 1'($urandom_range(0, 1));
         do_start(loop);
         go($urandom_range(20, 120));
         act = $urandom_range(0, 2);
         if (act == 0) do_stop(1'b0);
         else if (act == 1) do_start(loop);
         go(30);
         do_stop(1'b0);
         go(2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
